// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Load/store bus between the processor core (master) and the data-memory
//   responder (slave).
//   Address  : word address of the request           (master -> slave)
//   Alu_Out  : store data                             (master -> slave)
//   mw_en    : store request                          (master -> slave)
//   mr_en    : load request                           (master -> slave)
//   D_in     : load data returned to the core         (slave -> master)
//   d_valid  : D_in carries a load result this cycle  (slave -> master)
//   ready    : requests are accepted this cycle       (slave -> master)
//   oor_err  : sticky out-of-range request flag       (slave -> master)
interface data_mem_responder_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Alu_Out;
  logic              mw_en;
  logic              mr_en;
  logic [DATA_W-1:0] D_in;
  logic              d_valid;
  logic              ready;
  logic              oor_err;

  modport master (
    output Address, Alu_Out, mw_en, mr_en,
    input  D_in, d_valid, ready, oor_err
  );

  modport slave (
    input  Address, Alu_Out, mw_en, mr_en,
    output D_in, d_valid, ready, oor_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory end of the processor load/store interface. After reset the block
//   clears every word (one per cycle), then raises ready and services one
//   request per cycle. Loads return after a fixed READ_LAT-cycle pipeline;
//   out-of-range stores are dropped, out-of-range loads return zero, and
//   either sets the sticky oor_err flag.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : data_mem_responder_if.slave (Address, Alu_Out, mw_en, mr_en in;
//            D_in, d_valid, ready, oor_err out)
// Configuration macro
//   MEM_BYPASS_EN : defined   -> a load colliding with a same-cycle store
//                                returns the store data (write-first)
//                   undefined -> it returns the old contents (read-first)
// Parameters
//   DATA_W, ADDR_W must match the connected interface instance.
//   READ_LAT legal range is 1..4.
module data_mem_responder #(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  init_cnt;
  logic              ready_q;
  logic              oor_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              st_acc;
  logic              ld_acc;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_data;

  logic              stg_v [READ_LAT];
  logic [DATA_W-1:0] stg_d [READ_LAT];

  // The full address takes part in the range check; high bits are never dropped.
  assign in_range = ({1'b0, bus.Address} < DEPTH_A);
  assign idx      = bus.Address[IDX_W-1:0];
  assign st_acc   = ready_q & bus.mw_en & in_range;
  assign ld_acc   = ready_q & bus.mr_en;

  // Control FSM: clear sweep in INIT, then request service in RUN.
  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
      ready_q  <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + IDX_W'(1);
          if (init_cnt == LAST_IDX) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (ready_q && (bus.mw_en || bus.mr_en) && !in_range)
            oor_q <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Single write port shared by the clear sweep and accepted stores.
  // NOTE: defaults first so no path through always_comb leaves a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_cnt;
    mem_wdata = '0;
    if (state == INIT) begin
      mem_we = 1'b1;
    end else if (st_acc) begin
      mem_we    = 1'b1;
      mem_waddr = idx;
      mem_wdata = bus.Alu_Out;
    end
  end

  // NOTE: the array has no reset; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  // Read value captured at issue. Address is shared by store and load, so a
  // same-cycle store always targets the word being loaded.
  always_comb begin
    rd_data = '0;
    if (in_range)
      rd_data = mem[idx];
`ifdef MEM_BYPASS_EN
    if (st_acc)
      rd_data = bus.Alu_Out;
`endif
  end

  // Load pipeline. Each stage's data only moves with a valid token, so the
  // final stage (D_in) holds the last result while d_valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < READ_LAT; k++) begin
        stg_v[k] <= 1'b0;
        stg_d[k] <= '0;
      end
    end else begin
      stg_v[0] <= ld_acc;
      if (ld_acc)
        stg_d[0] <= rd_data;
      for (int k = 1; k < READ_LAT; k++) begin
        stg_v[k] <= stg_v[k-1];
        if (stg_v[k-1])
          stg_d[k] <= stg_d[k-1];
      end
    end
  end

  assign bus.D_in    = stg_d[READ_LAT-1];
  assign bus.d_valid = stg_v[READ_LAT-1];
  assign bus.ready   = ready_q;
  assign bus.oor_err = oor_q;

endmodule
